branch_unit: RTL and testbench
==============================

# branch_unit

Branch/jump resolution unit for the NPC RV64 core. It accepts a decoded control-transfer op from decode over a valid/ready handshake and drives the ALU compare unit's request side (operands plus 4-bit compare code). It then samples the compare result, computes the target and link address, and presents a registered resolution to the PC/fetch logic over a second valid/ready handshake.

## Interface
Parameters:
- XLEN, 64, datapath width; all address, operand and result buses are XLEN bits.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous pipeline flush; kills any in-flight op.
- in_valid  input  1  decode offers an op.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_pc  input  XLEN  PC of the instruction.
- in_imm  input  XLEN  sign-extended immediate.
- in_src1, in_src2  input  XLEN  rs1/rs2 values.
- in_funct3  input  3  branch funct3.
- in_is_jal, in_is_jalr  input  1  unconditional jump type; both low means conditional branch.
- cmp_src1, cmp_src2  output  XLEN  operands to the compare unit.
- cmp_ctrl  output  4  compare code: 0 neq, 1 eq, 2 ge signed, 3 lt signed, 4 ltu, 5 geu.
- cmp_result  input  XLEN  compare unit result, combinational; only bit 0 is used.
- out_valid  output  1  resolution available.
- out_ready  input  1  PC logic accepts the resolution.
- out_taken  output  1  control transfer taken.
- out_target  output  XLEN  next PC.
- out_link  output  XLEN  in_pc+4, the rd write value for jal/jalr.
- out_misalign  output  1  a taken target has a nonzero [1:0].
- out_illegal  output  1  funct3 is 010 or 011 on a conditional branch.
- cnt_branch, cnt_taken  output  CNT_W  retired-op and taken-op counters.

## Operation
- FSM states: IDLE, EVAL, RESP.
- **IDLE**
  - in_ready=1.
  - If in_valid, all in_* are latched and the FSM goes to EVAL.
- **EVAL**
  - cmp_src1/cmp_src2 are driven from the latched src1/src2.
  - cmp_ctrl maps from funct3: 000→1, 001→0, 100→3, 101→2, 110→4, 111→5, others→0 and illegal is set.
  - Jumps drive cmp_ctrl=1 with the compare result ignored.
  - The following are registered, then the FSM goes to RESP:
    - taken = jal|jalr|(cmp_result[0] & !illegal).
    - target:
      - jalr: (src1+imm)&~1.
      - jal/branch taken: pc+imm.
      - not taken: pc+4.
    - link = pc+4.
    - misalign = taken & (target[1:0]!=0).
- Outside EVAL, cmp_src1/cmp_src2 hold the latched values and cmp_ctrl=0.
- **RESP**
  - out_valid=1 and all out_* fields are held stable until out_ready.
  - On out_valid&out_ready: cnt_branch increments; cnt_taken increments if out_taken; the FSM goes to IDLE.
- **Illegal funct3:** forces taken=0 and target=pc+4, with out_illegal=1.
- **Arithmetic:** modulo 2^XLEN; pc+imm and src1+imm wrap silently.
- **Counters:** wrap at 2^CNT_W.
- **flush:** in any state, next state is IDLE, out_valid drops, counters are not updated, and a simultaneous in_valid is not accepted. flush outranks a RESP handshake in the same cycle; that op is not counted.
- **Reset:** see the reset values under Timing.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_taken=0, out_misalign=0, out_illegal=0. out_target, out_link, cmp_src1, cmp_src2, cmp_ctrl and both counters are 0; all latched registers are 0.
- Latency: op accepted at edge N; EVAL occupies cycle N..N+1; out_valid is high after edge N+1.
- Minimum issue interval is 3 cycles; in_ready is low from the accept edge until the cycle after the out handshake.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.
- cmp_result is sampled only at the EVAL→RESP edge.
- Reset asserted mid-operation clears immediately (asynchronous); the op is lost.

## Test plan
- **BEQ taken:** pc=0x80000000, imm=0x10, src1=src2=5 → cmp_ctrl=1 in EVAL; out_valid two edges after accept; taken=1, target=0x80000010, link=0x80000004.
- **BLT signed vs BLTU:**
  - src1=0xFFFF_FFFF_FFFF_FFFF, src2=1, funct3=100 → taken=1.
  - Same operands with funct3=110 → taken=0, target=pc+4.
- **JALR:** src1=0x80001003, imm=0 → target=0x80001002, out_misalign=1, taken=1.
- **Backpressure:** out_ready held low 5 cycles → out_* stable, in_ready=0, counters unchanged; releasing out_ready → cnt_branch+1, in_ready=1 next cycle.
- **Illegal funct3=010:** → out_illegal=1, taken=0, target=pc+4.
- **flush during RESP with out_ready=1, and reset mid-EVAL:** flush → no count, state IDLE. Reset mid-EVAL → all outputs at reset values immediately.

Source files
------------

// File: rtl/branch_unit.sv
// Branch/jump resolution: latches a control-transfer op, drives the compare
// unit for one cycle, then holds a registered resolution for the PC logic.
module branch_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [2:0]       in_funct3,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  output logic [XLEN-1:0]  cmp_src1,
  output logic [XLEN-1:0]  cmp_src2,
  output logic [3:0]       cmp_ctrl,
  input  logic [XLEN-1:0]  cmp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_misalign,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]  pc_q, imm_q, src1_q, src2_q;
  logic [2:0]       f3_q;
  logic             jal_q, jalr_q;
  logic             taken_q, misalign_q, illegal_q;
  logic [XLEN-1:0]  target_q, link_q;
  logic [CNT_W-1:0] cnt_b_q, cnt_t_q;

  logic             jump, illegal_d, taken_d, misalign_d;
  logic [3:0]       ctrl_map, ctrl_eval;
  logic [XLEN-1:0]  pc_sum, rs_sum, link_d, target_d;
  logic             accept, load_res, retire;

  // Only bit 0 of the compare result carries meaning.
  logic unused_cmp;
  assign unused_cmp = ^cmp_result[XLEN-1:1];

  always_comb begin
    ctrl_map = 4'd0;
    unique case (f3_q)
      3'b000:  ctrl_map = 4'd1;
      3'b001:  ctrl_map = 4'd0;
      3'b100:  ctrl_map = 4'd3;
      3'b101:  ctrl_map = 4'd2;
      3'b110:  ctrl_map = 4'd4;
      3'b111:  ctrl_map = 4'd5;
      default: ctrl_map = 4'd0;
    endcase
  end

  always_comb begin
    jump      = jal_q | jalr_q;
    illegal_d = !jump && (f3_q == 3'b010 || f3_q == 3'b011);
    ctrl_eval = jump ? 4'd1 : ctrl_map;
    taken_d   = jump | (cmp_result[0] & !illegal_d);
    pc_sum    = pc_q + imm_q;
    rs_sum    = src1_q + imm_q;
    link_d    = pc_q + XLEN'(4);
    if (jalr_q)       target_d = {rs_sum[XLEN-1:1], 1'b0};
    else if (taken_d) target_d = pc_sum;
    else              target_d = link_d;
    misalign_d = taken_d & (target_d[1:0] != 2'b00);
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_res = 1'b0;
    retire   = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          accept  = 1'b1;
          state_d = EVAL;
        end
        EVAL: begin
          load_res = 1'b1;
          state_d  = RESP;
        end
        RESP: if (out_ready) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      imm_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      f3_q    <= '0;
      jal_q   <= 1'b0;
      jalr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q   <= in_pc;
        imm_q  <= in_imm;
        src1_q <= in_src1;
        src2_q <= in_src2;
        f3_q   <= in_funct3;
        jal_q  <= in_is_jal;
        jalr_q <= in_is_jalr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q    <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      target_q   <= '0;
      link_q     <= '0;
      cnt_b_q    <= '0;
      cnt_t_q    <= '0;
    end else begin
      if (load_res) begin
        taken_q    <= taken_d;
        misalign_q <= misalign_d;
        illegal_q  <= illegal_d;
        target_q   <= target_d;
        link_q     <= link_d;
      end
      if (retire) begin
        cnt_b_q <= cnt_b_q + CNT_W'(1);
        if (taken_q) cnt_t_q <= cnt_t_q + CNT_W'(1);
      end
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == RESP);
  assign cmp_src1     = src1_q;
  assign cmp_src2     = src2_q;
  assign cmp_ctrl     = (state_q == EVAL) ? ctrl_eval : 4'd0;
  assign out_taken    = taken_q;
  assign out_target   = target_q;
  assign out_link     = link_q;
  assign out_misalign = misalign_q;
  assign out_illegal  = illegal_q;
  assign cnt_branch   = cnt_b_q;
  assign cnt_taken    = cnt_t_q;

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed vector table, corner sequences and
// randomized ops checked against a behavioural resolution model.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_taken, out_misalign, out_illegal;
  logic [63:0] in_pc, in_imm, in_src1, in_src2;
  logic [2:0]  in_funct3;
  logic        in_is_jal, in_is_jalr;
  logic [63:0] cmp_src1, cmp_src2, cmp_result, out_target, out_link;
  logic [3:0]  cmp_ctrl;
  logic [31:0] cnt_branch, cnt_taken;

  int checks = 0;
  int failures = 0;
  int exp_cb = 0;
  int exp_ct = 0;

  always #5 clk = ~clk;

  branch_unit #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_src1(in_src1), .in_src2(in_src2),
    .in_funct3(in_funct3),
    .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .cmp_src1(cmp_src1), .cmp_src2(cmp_src2),
    .cmp_ctrl(cmp_ctrl), .cmp_result(cmp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target),
    .out_link(out_link), .out_misalign(out_misalign),
    .out_illegal(out_illegal),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
  );

  // Environment model of the ALU compare unit.
  always_comb begin
    cmp_result = 64'd0;
    case (cmp_ctrl)
      4'd0: cmp_result[0] = (cmp_src1 != cmp_src2);
      4'd1: cmp_result[0] = (cmp_src1 == cmp_src2);
      4'd2: cmp_result[0] = ($signed(cmp_src1) >= $signed(cmp_src2));
      4'd3: cmp_result[0] = ($signed(cmp_src1) < $signed(cmp_src2));
      4'd4: cmp_result[0] = (cmp_src1 < cmp_src2);
      4'd5: cmp_result[0] = (cmp_src1 >= cmp_src2);
      default: cmp_result[0] = 1'b0;
    endcase
  end

  typedef struct {
    logic [63:0] pc, imm, s1, s2;
    logic [2:0]  f3;
    logic        jal, jalr;
    logic        e_taken;
    logic [63:0] e_tgt;
    logic        e_mis, e_ill;
    logic [3:0]  e_ctrl;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Resolution computed directly from RISC-V branch semantics.
  function automatic vec_t model(input logic [63:0] pc, imm, s1, s2,
                                 input logic [2:0] f3,
                                 input logic jal, jalr);
    vec_t v;
    logic [63:0] sum;
    v.pc = pc; v.imm = imm; v.s1 = s1; v.s2 = s2;
    v.f3 = f3; v.jal = jal; v.jalr = jalr;
    v.e_ill = 1'b0;
    v.e_ctrl = 4'd1;
    if (jal || jalr) begin
      v.e_taken = 1'b1;
    end else begin
      case (f3)
        3'b000: begin v.e_taken = (s1 == s2); v.e_ctrl = 4'd1; end
        3'b001: begin v.e_taken = (s1 != s2); v.e_ctrl = 4'd0; end
        3'b100: begin
          v.e_taken = ($signed(s1) < $signed(s2)); v.e_ctrl = 4'd3;
        end
        3'b101: begin
          v.e_taken = ($signed(s1) >= $signed(s2)); v.e_ctrl = 4'd2;
        end
        3'b110: begin v.e_taken = (s1 < s2); v.e_ctrl = 4'd4; end
        3'b111: begin v.e_taken = (s1 >= s2); v.e_ctrl = 4'd5; end
        default: begin
          v.e_taken = 1'b0; v.e_ctrl = 4'd0; v.e_ill = 1'b1;
        end
      endcase
    end
    if (jalr) begin
      sum = s1 + imm;
      v.e_tgt = sum & ~64'd1;
    end else if (v.e_taken) begin
      v.e_tgt = pc + imm;
    end else begin
      v.e_tgt = pc + 64'd4;
    end
    v.e_mis = v.e_taken && (v.e_tgt % 4 != 0);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_pc = v.pc; in_imm = v.imm;
    in_src1 = v.s1; in_src2 = v.s2;
    in_funct3 = v.f3;
    in_is_jal = v.jal; in_is_jalr = v.jalr;
    in_valid = 1'b1;
  endtask

  task automatic chk_resp(input vec_t v);
    chk("out_valid", {63'd0, out_valid}, 64'd1);
    chk("in_ready_resp", {63'd0, in_ready}, 64'd0);
    chk("taken", {63'd0, out_taken}, {63'd0, v.e_taken});
    chk("target", out_target, v.e_tgt);
    chk("link", out_link, v.pc + 64'd4);
    chk("misalign", {63'd0, out_misalign}, {63'd0, v.e_mis});
    chk("illegal", {63'd0, out_illegal}, {63'd0, v.e_ill});
    chk("cnt_branch", {32'd0, cnt_branch}, 64'(exp_cb));
    chk("cnt_taken", {32'd0, cnt_taken}, 64'(exp_ct));
  endtask

  // Issue one op, hold out_ready low for dly cycles, then retire it.
  task automatic run_op(input vec_t v, input int dly);
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    drive(v);
    @(negedge clk);
    in_valid = 1'b0;
    chk("eval_valid", {63'd0, out_valid}, 64'd0);
    chk("eval_ready", {63'd0, in_ready}, 64'd0);
    chk("cmp_ctrl", {60'd0, cmp_ctrl}, {60'd0, v.e_ctrl});
    chk("cmp_src1", cmp_src1, v.s1);
    chk("cmp_src2", cmp_src2, v.s2);
    @(negedge clk);
    for (int i = 0; i <= dly; i++) begin
      chk_resp(v);
      chk("resp_ctrl", {60'd0, cmp_ctrl}, 64'd0);
      if (i < dly) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cb++;
    if (v.e_taken) exp_ct++;
    chk("post_valid", {63'd0, out_valid}, 64'd0);
    chk("post_ready", {63'd0, in_ready}, 64'd1);
    chk("post_cnt_b", {32'd0, cnt_branch}, 64'(exp_cb));
    chk("post_cnt_t", {32'd0, cnt_taken}, 64'(exp_ct));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_taken"}, {63'd0, out_taken}, 64'd0);
    chk({tag, "_mis"}, {63'd0, out_misalign}, 64'd0);
    chk({tag, "_ill"}, {63'd0, out_illegal}, 64'd0);
    chk({tag, "_target"}, out_target, 64'd0);
    chk({tag, "_link"}, out_link, 64'd0);
    chk({tag, "_src1"}, cmp_src1, 64'd0);
    chk({tag, "_src2"}, cmp_src2, 64'd0);
    chk({tag, "_ctrl"}, {60'd0, cmp_ctrl}, 64'd0);
    chk({tag, "_cnt_b"}, {32'd0, cnt_branch}, 64'd0);
    chk({tag, "_cnt_t"}, {32'd0, cnt_taken}, 64'd0);
  endtask

  vec_t tbl [11];
  vec_t rv;

  initial begin
    tbl[0]  = '{64'h8000_0000, 64'h10, 64'd5, 64'd5, 3'b000, 1'b0, 1'b0,
                1'b1, 64'h8000_0010, 1'b0, 1'b0, 4'd1};
    tbl[1]  = '{64'h1000, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100,
                1'b0, 1'b0, 1'b1, 64'h1020, 1'b0, 1'b0, 4'd3};
    tbl[2]  = '{64'h1000, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b110,
                1'b0, 1'b0, 1'b0, 64'h1004, 1'b0, 1'b0, 4'd4};
    tbl[3]  = '{64'h2000, 64'h0, 64'h8000_1003, 64'd0, 3'b000,
                1'b0, 1'b1, 1'b1, 64'h8000_1002, 1'b1, 1'b0, 4'd1};
    tbl[4]  = '{64'h3000, 64'h40, 64'd1, 64'd2, 3'b010, 1'b0, 1'b0,
                1'b0, 64'h3004, 1'b0, 1'b1, 4'd0};
    tbl[5]  = '{64'h4000, 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 64'd4, 3'b001,
                1'b1, 1'b0, 1'b1, 64'h3FF8, 1'b0, 1'b0, 4'd1};
    tbl[6]  = '{64'h5000, 64'h100, 64'd9, 64'd9, 3'b001, 1'b0, 1'b0,
                1'b0, 64'h5004, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFF, 3'b101, 1'b0, 1'b0,
                1'b1, 64'h10, 1'b0, 1'b0, 4'd2};
    tbl[8]  = '{64'h6000, 64'h20, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111,
                1'b0, 1'b0, 1'b0, 64'h6004, 1'b0, 1'b0, 4'd5};
    tbl[9]  = '{64'h7000, 64'h6, 64'd2, 64'd2, 3'b000, 1'b0, 1'b0,
                1'b1, 64'h7006, 1'b1, 1'b0, 4'd1};
    tbl[10] = '{64'h7100, 64'h6, 64'd2, 64'd2, 3'b011, 1'b0, 1'b0,
                1'b0, 64'h7104, 1'b0, 1'b1, 4'd0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_imm = '0; in_src1 = '0; in_src2 = '0;
    in_funct3 = '0; in_is_jal = 1'b0; in_is_jalr = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    run_op(tbl[0], 5);
    for (int i = 1; i < 11; i++) run_op(tbl[i], i % 3);

    // flush outranks a RESP handshake; op not counted
    @(negedge clk);
    drive(tbl[0]);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_resp_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0;
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready}, 64'd1);
    chk("fl_cnt_b", {32'd0, cnt_branch}, 64'(exp_cb));
    chk("fl_cnt_t", {32'd0, cnt_taken}, 64'(exp_ct));

    // flush with in_valid in IDLE must not accept
    drive(tbl[1]); flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_ready", {63'd0, in_ready}, 64'd1);
    chk("fl_idle_ctrl", {60'd0, cmp_ctrl}, 64'd0);
    @(negedge clk);
    chk("fl_idle_valid", {63'd0, out_valid}, 64'd0);

    // flush during EVAL kills the op
    drive(tbl[2]);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_eval_ready", {63'd0, in_ready}, 64'd1);
    chk("fl_eval_valid", {63'd0, out_valid}, 64'd0);

    for (int n = 0; n < 150; n++) begin
      logic [63:0] pc, imm, s1, s2;
      logic [2:0] f3;
      int kind;
      pc  = {$urandom, $urandom} & ~64'd3;
      imm = 64'($signed($urandom_range(0, 8191)) - 4096);
      if ($urandom_range(0, 7) == 0) pc = 64'hFFFF_FFFF_FFFF_FFF0;
      s1  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: s2 = s1;
        1: s2 = s1 ^ 64'h8000_0000_0000_0000;
        default: s2 = {$urandom, $urandom};
      endcase
      f3 = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 5);
      rv = model(pc, imm, s1, s2, f3, kind == 0, kind == 1);
      run_op(rv, $urandom_range(0, 2));
    end

    // reset mid-EVAL clears everything at once
    @(negedge clk);
    drive(tbl[3]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_eval", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    #1;
    exp_cb = 0; exp_ct = 0;
    chk_reset_vals("rst_eval");
    @(negedge clk);
    rst = 1'b0;
    run_op(tbl[9], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
